// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the wishbone round-robin arbiter.
package wb_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_OWNED, ARB_DRAIN} arb_state_e;
  localparam int ARB_TIMEOUT_DFLT = 255;
endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin pick: rotate req so ptr sits at bit 0, find first set, rotate back.
module rr_prio_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] ffs;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) rot[i] = req[(i + int'(ptr)) % N];
    valid = |req;
    ffs   = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) ffs = IDX_W'(i);
    idx = IDX_W'((int'(ffs) + int'(ptr)) % N);
  end
endmodule

// File: rtl/wb_rr_arbiter.sv
// Registered round-robin bus owner for the wishbone crossbar; masks stale responses
// after owner change/abort and times out hung slaves.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int N_MASTER       = 2,
  parameter  int TIMEOUT_CYCLES = ARB_TIMEOUT_DFLT,
  localparam int IDX_W          = $clog2(N_MASTER)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_MASTER-1:0] m_cyc_i,
  input  logic [N_MASTER-1:0] m_stb_i,
  input  logic [N_MASTER-1:0] m_lock_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic                s_rty_i,
  output logic [N_MASTER-1:0] gnt_o,
  output logic [IDX_W-1:0]    gnt_idx_o,
  output logic                busy_o,
  output logic                resp_en_o,
  output logic                s_cyc_en_o,
  output logic                to_err_o
);
  localparam bit                TO_EN    = TIMEOUT_CYCLES > 0;
  localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_MASTER - 1);
  localparam logic [N_MASTER-1:0] ONE    = {{(N_MASTER-1){1'b0}}, 1'b1};

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic             pending;
  logic [CNT_W-1:0] to_cnt;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             own_cyc, own_stb, own_lock, resp, pend_nxt, to_hit;

  rr_prio_pick #(.N(N_MASTER), .IDX_W(IDX_W)) u_pick (
    .req   (m_cyc_i),
    .ptr   (rr_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign own_cyc  = m_cyc_i[gnt_idx_o];
  assign own_stb  = own_cyc & m_stb_i[gnt_idx_o];
  assign own_lock = m_lock_i[gnt_idx_o];
  assign resp     = s_ack_i | s_err_i | s_rty_i;
  // same-cycle stb+response completes immediately, so the response has priority
  assign pend_nxt = resp ? 1'b0 : (own_stb | pending);
  assign to_hit   = TO_EN && pending && (to_cnt == TO_LAST) && !resp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ARB_IDLE;
      gnt_o     <= '0;
      gnt_idx_o <= '0;
      rr_ptr    <= '0;
      pending   <= 1'b0;
      to_cnt    <= '0;
      to_err_o  <= 1'b0;
    end else begin
      to_err_o <= 1'b0;
      case (state)
        ARB_IDLE: if (pick_vld) begin
          state     <= ARB_OWNED;
          gnt_o     <= ONE << pick_idx;
          gnt_idx_o <= pick_idx;
          rr_ptr    <= (pick_idx == IDX_LAST) ? '0 : pick_idx + IDX_W'(1);
          pending   <= 1'b0;
          to_cnt    <= '0;
        end
        ARB_OWNED: begin
          if (to_hit) begin
            to_err_o <= 1'b1;
            pending  <= 1'b0;
            to_cnt   <= '0;
            state    <= ARB_DRAIN;
          end else begin
            pending <= pend_nxt;
            to_cnt  <= (TO_EN && pending && !resp) ? to_cnt + CNT_W'(1) : '0;
            // lock keeps ownership across a cyc gap; released by lock=0 with cyc=0
            if (!own_cyc && !own_lock) begin
              if (pend_nxt) begin
                state   <= ARB_DRAIN;
                pending <= 1'b0;
                to_cnt  <= '0;
              end else begin
                state <= ARB_IDLE;
                gnt_o <= '0;
              end
            end
          end
        end
        ARB_DRAIN: begin
          if (resp || (TO_EN && to_cnt == TO_LAST)) begin
            state  <= ARB_IDLE;
            gnt_o  <= '0;
            to_cnt <= '0;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ARB_IDLE;
          gnt_o <= '0;
        end
      endcase
    end
  end

  assign busy_o     = (state != ARB_IDLE);
  assign resp_en_o  = (state == ARB_OWNED);
  assign s_cyc_en_o = (state == ARB_OWNED);

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));
  a_no_resp_in_drain: assert property (@(posedge clk_i) disable iff (rst_i)
    !(resp_en_o && state == ARB_DRAIN));
  a_to_err_edge: assert property (@(posedge clk_i) disable iff (rst_i)
    to_err_o |-> $past(state) == ARB_OWNED);
endmodule
